spi_controller: RTL and testbench
=================================

SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 SHALL have parameter: CLK_DIV, 4, SCLK half-period in clk cycles; legal range 4..255.
REQ-002 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request one frame; sampled only while busy=0.
REQ-005 SHALL have port: wr  input  1  R/W bit of frame (1=write).
REQ-006 SHALL have port: addr  input  7  register address.
REQ-007 SHALL have port: wdata  input  8  write data.
REQ-008 SHALL have port: cipo  input  1  serial data from peripheral (used only with SPI_CTRL_READ_EN).
REQ-009 SHALL have port: busy  output  1  frame in progress.
REQ-010 SHALL have port: done  output  1  one-cycle pulse at frame end.
REQ-011 SHALL have port: rdata  output  8  captured read data.
REQ-012 SHALL have port: sclk  output  1  SPI clock, idle low (mode 0).
REQ-013 SHALL have port: copi  output  1  serial data to peripheral.
REQ-014 SHALL have port: ncs  output  1  chip select, active low.

Function
REQ-015 SHALL, on a cycle with start=1 and busy=0, latch frame {wr, addr, wdata} (16 bits, MSB first) into a shift register; inputs are ignored afterwards.
REQ-016 SHALL implement states IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP, each timed by a divider counter of CLK_DIV cycles.
REQ-017 SHALL, in the cycle after start is accepted, enter SETUP with busy=1, ncs=0, sclk=0, copi=frame bit 15.
REQ-018 SHALL go SETUP -> SHIFT_HI after CLK_DIV cycles; SHIFT_HI drives sclk=1 for CLK_DIV cycles, then SHIFT_LO drives sclk=0 for CLK_DIV cycles.
REQ-019 SHALL update copi to the next frame bit only on entry to SHIFT_LO, so copi is stable for CLK_DIV cycles on both sides of every sclk rising edge.
REQ-020 SHALL count bits 0..15 with a 4-bit counter; after SHIFT_LO of bit 15, go to HOLD (ncs=0, sclk=0) for CLK_DIV cycles.
REQ-021 SHALL produce exactly 16 sclk rising edges per frame and hold ncs low for exactly 34*CLK_DIV cycles.
REQ-022 SHALL go HOLD -> GAP with ncs=1 for CLK_DIV cycles; done=1 in the last GAP cycle; IDLE with busy=0 in the following cycle.
REQ-023 SHALL ignore start while busy=1; a start held high through done begins the next frame in the first IDLE cycle.
REQ-024 SHALL drive copi=0 whenever ncs=1.
REQ-025 SHALL keep rdata unchanged except as specified in REQ-030.

Reset
REQ-026 SHALL, when rst=1 at a clock edge, set state=IDLE, busy=0, done=0, sclk=0, copi=0, ncs=1, rdata=0, and clear counters and shift register.
REQ-027 SHALL, on reset mid-frame, abort at the next edge (ncs high, sclk low) with no done pulse.
REQ-028 SHALL take rst precedence over start in the same cycle.

Configuration
REQ-029 SHALL compile the read-back path only when macro SPI_CTRL_READ_EN is defined.
REQ-030 SHALL, with SPI_CTRL_READ_EN and wr=0, sample cipo on each sclk rising edge of bits 8..15 (MSB first) and load rdata with the 8 sampled bits in the cycle done=1.
REQ-031 SHALL, without SPI_CTRL_READ_EN, ignore cipo and hold rdata at 0.

Verification
REQ-032 SHALL check CLK_DIV=4, wr=1, addr=0x04, wdata=0xA5 -> copi bits sampled at the 16 sclk rises = 0x84A5; ncs low 136 cycles; one done.
REQ-033 SHALL check start pulse while busy=1 (addr=0x01) -> ignored; only the first frame appears on the bus; one done.
REQ-034 SHALL check start held high for 3 frames, wdata=0x00/0xFF/0x5A -> three frames each separated by exactly CLK_DIV cycles of ncs=1; three done pulses.
REQ-035 SHALL check rst=1 in the cycle after the 7th sclk rise -> next cycle ncs=1, sclk=0, busy=0; no done; subsequent frame 0x8133 correct.
REQ-036 SHALL check with SPI_CTRL_READ_EN, wr=0, addr=0x02, model driving cipo=0x3C on bits 8..15 -> rdata=0x3C when done=1; without macro rdata=0.
REQ-037 SHALL check CLK_DIV=7 frame 0x8203 -> every sclk high and low phase lasts 7 cycles; copi never changes within 7 cycles of a rise.

Source files
------------

// File: rtl/spi_controller.sv
// SPI mode-0 register-write controller: 16-bit frame {wr, addr, wdata}, MSB first.
// Define SPI_CTRL_READ_EN to build the cipo read-back path into rdata.
module spi_controller #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       wr,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    input  logic       cipo,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       sclk,
    output logic       copi,
    output logic       ncs
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        HOLD,
        GAP
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] DIV_PRE  = 8'(CLK_DIV - 2);

    state_t      state;
    logic [7:0]  div;
    logic [3:0]  bit_cnt;
    // copi holds frame bit 15; the remaining 15 bits wait here
    logic [14:0] shreg;
    logic        div_end;

    assign div_end = (div == DIV_LAST);

`ifdef SPI_CTRL_READ_EN
    logic       rd_frame;
    logic [7:0] rx_sh;
`else
    logic unused_cipo;
    assign unused_cipo = cipo;
    assign rdata       = 8'h00;
`endif

    // Frame sequencer: every phase lasts one divider period; the gap is one
    // cycle short so that gap plus the idle cycle give CLK_DIV cycles of ncs high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            div     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sclk    <= 1'b0;
            copi    <= 1'b0;
            ncs     <= 1'b1;
`ifdef SPI_CTRL_READ_EN
            rd_frame <= 1'b0;
            rx_sh    <= '0;
            rdata    <= '0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= SETUP;
                        busy    <= 1'b1;
                        ncs     <= 1'b0;
                        sclk    <= 1'b0;
                        copi    <= wr;
                        shreg   <= {addr, wdata};
                        div     <= '0;
                        bit_cnt <= '0;
`ifdef SPI_CTRL_READ_EN
                        rd_frame <= ~wr;
`endif
                    end
                end
                SETUP: begin
                    if (div_end) begin
                        state <= SHIFT_HI;
                        sclk  <= 1'b1;
                        div   <= '0;
                    end else begin
                        div <= div + 8'd1;
                    end
                end
                SHIFT_HI: begin
                    if (div_end) begin
                        state <= SHIFT_LO;
                        sclk  <= 1'b0;
                        copi  <= shreg[14];
                        shreg <= {shreg[13:0], 1'b0};
                        div   <= '0;
`ifdef SPI_CTRL_READ_EN
                        if (bit_cnt[3]) begin
                            rx_sh <= {rx_sh[6:0], cipo};
                        end
`endif
                    end else begin
                        div <= div + 8'd1;
                    end
                end
                SHIFT_LO: begin
                    if (div_end) begin
                        div <= '0;
                        if (bit_cnt == 4'd15) begin
                            state <= HOLD;
                        end else begin
                            state   <= SHIFT_HI;
                            sclk    <= 1'b1;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        div <= div + 8'd1;
                    end
                end
                HOLD: begin
                    if (div_end) begin
                        state <= GAP;
                        ncs   <= 1'b1;
                        copi  <= 1'b0;
                        div   <= 8'd1;
                    end else begin
                        div <= div + 8'd1;
                    end
                end
                GAP: begin
                    if (div == DIV_PRE) begin
                        done <= 1'b1;
`ifdef SPI_CTRL_READ_EN
                        if (rd_frame) begin
                            rdata <= rx_sh;
                        end
`endif
                    end
                    if (div_end) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        div   <= '0;
                    end else begin
                        div <= div + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: bus monitor per instance (CLK_DIV 4 and 7),
// hand-computed frames, timing and read-back expectations.
module tb_spi_controller;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start4, wr4, cipo4, busy4, done4, sclk4, copi4, ncs4;
    logic [6:0] addr4;
    logic [7:0] wdata4, rdata4;
    logic       start7, wr7, cipo7, busy7, done7, sclk7, copi7, ncs7;
    logic [6:0] addr7;
    logic [7:0] wdata7, rdata7;

    spi_controller #(.CLK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .wr(wr4), .addr(addr4),
        .wdata(wdata4), .cipo(cipo4), .busy(busy4), .done(done4),
        .rdata(rdata4), .sclk(sclk4), .copi(copi4), .ncs(ncs4)
    );

    spi_controller #(.CLK_DIV(7)) dut7 (
        .clk(clk), .rst(rst), .start(start7), .wr(wr7), .addr(addr7),
        .wdata(wdata7), .cipo(cipo7), .busy(busy7), .done(done7),
        .rdata(rdata7), .sclk(sclk7), .copi(copi7), .ncs(ncs7)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // bus monitor state, index 0 = dut4, 1 = dut7
    logic        mon_on;
    logic [15:0] resp;
    logic        p_sclk[2], p_ncs[2], p_copi[2];
    int          rises[2], hi_run[2], lo_run[2], since_copi[2], since_rise[2];
    int          low_run[2], nh_run[2], last_low[2], done_cnt[2], viol[2];
    int          fcnt[2], gcnt[2];
    logic [15:0] cap[2];
    logic [15:0] flog[2][8];
    int          frise[2][8];
    int          glog[2][8];
    logic [7:0]  rd_at_done[2];

    task automatic mon(input int k, input int dv, input logic s,
                       input logic c, input logic n, input logic d,
                       input logic [7:0] rd);
        logic rise;
        rise = s && !p_sclk[k];
        if (n && c) viol[k]++;
        if (d) begin
            done_cnt[k]++;
            rd_at_done[k] = rd;
        end
        if (!n && p_ncs[k]) begin
            if (fcnt[k] > 0 && gcnt[k] < 8) begin
                glog[k][gcnt[k]] = nh_run[k];
                gcnt[k]++;
            end
            rises[k] = 0;
            cap[k] = '0;
            lo_run[k] = 0;
            low_run[k] = 0;
            since_rise[k] = 1000;
            if (k == 0) cipo4 = resp[15];
        end
        if (n && !p_ncs[k]) begin
            last_low[k] = low_run[k];
            if (fcnt[k] < 8) begin
                flog[k][fcnt[k]] = cap[k];
                frise[k][fcnt[k]] = rises[k];
            end
            fcnt[k]++;
            nh_run[k] = 0;
        end
        if (n) nh_run[k]++;
        else low_run[k]++;
        if (rise) begin
            if (lo_run[k] != dv) viol[k]++;
            if (since_copi[k] < dv) viol[k]++;
            rises[k]++;
            cap[k] = {cap[k][14:0], c};
            hi_run[k] = 1;
            since_rise[k] = 0;
        end else begin
            since_rise[k]++;
            if (s) begin
                hi_run[k]++;
            end else if (p_sclk[k]) begin
                if (hi_run[k] != dv) viol[k]++;
                lo_run[k] = 1;
                if (k == 0) cipo4 = (rises[0] < 16) ? resp[15 - rises[0]] : 1'b0;
            end else begin
                lo_run[k]++;
            end
        end
        if (c != p_copi[k]) begin
            if (since_rise[k] < dv) viol[k]++;
            since_copi[k] = 1;
        end else begin
            since_copi[k]++;
        end
        p_sclk[k] = s;
        p_ncs[k] = n;
        p_copi[k] = c;
    endtask

    always @(negedge clk) begin
        if (mon_on && !rst) begin
            mon(0, 4, sclk4, copi4, ncs4, done4, rdata4);
            mon(1, 7, sclk7, copi7, ncs7, done7, rdata7);
        end
    end

    task automatic clear_mon();
        for (int k = 0; k < 2; k++) begin
            p_sclk[k] = 1'b0;
            p_ncs[k] = 1'b1;
            p_copi[k] = 1'b0;
            rises[k] = 0;
            hi_run[k] = 0;
            lo_run[k] = 0;
            since_copi[k] = 1000;
            since_rise[k] = 1000;
            low_run[k] = 0;
            nh_run[k] = 0;
            last_low[k] = 0;
            done_cnt[k] = 0;
            viol[k] = 0;
            fcnt[k] = 0;
            gcnt[k] = 0;
            cap[k] = '0;
            rd_at_done[k] = '0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send4(input logic w, input logic [6:0] a,
                         input logic [7:0] d);
        wr4 = w;
        addr4 = a;
        wdata4 = d;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        wr4 = ~w;
        addr4 = ~a;
        wdata4 = ~d;
    endtask

    task automatic wait_done(input int k, input int target, input string tag);
        int n;
        n = 0;
        while (n < 5000 && (done_cnt[k] < target ||
               (k == 0 ? busy4 : busy7))) begin
            tick();
            n++;
        end
        if (n >= 5000) chk(tag, 32'd0, 32'd1);
    endtask

    logic [7:0] exp_rd;

    initial begin
        int n;
        int seen;
        int dn;
`ifdef SPI_CTRL_READ_EN
        exp_rd = 8'h3C;
`else
        exp_rd = 8'h00;
`endif
        mon_on = 1'b0;
        resp = '0;
        rst = 1'b1;
        start4 = 0; wr4 = 0; addr4 = 0; wdata4 = 0; cipo4 = 0;
        start7 = 0; wr7 = 0; addr7 = 0; wdata7 = 0; cipo7 = 0;
        clear_mon();
        repeat (3) tick();
        chk("rst_busy", busy4, 1'b0);
        chk("rst_done", done4, 1'b0);
        chk("rst_sclk", sclk4, 1'b0);
        chk("rst_copi", copi4, 1'b0);
        chk("rst_ncs", ncs4, 1'b1);
        chk("rst_rdata", rdata4, 8'h00);
        chk("rst_ncs7", ncs7, 1'b1);
        chk("rst_busy7", busy7, 1'b0);
        rst = 1'b0;
        mon_on = 1'b1;
        tick();

        // basic write frame
        send4(1'b1, 7'h04, 8'hA5);
        wait_done(0, 1, "w1_timeout");
        chk("w1_frame", flog[0][0], 16'h84A5);
        chk("w1_rises", frise[0][0], 16);
        chk("w1_ncs_low", last_low[0], 136);
        chk("w1_done", done_cnt[0], 1);
        chk("w1_timing", viol[0], 0);
        chk("w1_rdata", rdata4, 8'h00);

        // start while busy is ignored
        clear_mon();
        send4(1'b1, 7'h10, 8'h3C);
        repeat (40) tick();
        wr4 = 1'b1; addr4 = 7'h01; wdata4 = 8'hEE; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        wait_done(0, 1, "busy_timeout");
        repeat (200) tick();
        chk("busy_frames", fcnt[0], 1);
        chk("busy_frame", flog[0][0], 16'h903C);
        chk("busy_done", done_cnt[0], 1);
        chk("busy_idle", busy4, 1'b0);

        // start held high: back-to-back frames
        clear_mon();
        wr4 = 1'b1; addr4 = 7'h04; wdata4 = 8'h00; start4 = 1'b1;
        seen = 0;
        n = 0;
        while (seen < 3 && n < 3000) begin
            tick();
            n++;
            if (done4) begin
                seen++;
                if (seen == 1) wdata4 = 8'hFF;
                else if (seen == 2) wdata4 = 8'h5A;
                else start4 = 1'b0;
            end
        end
        if (n >= 3000) chk("held_timeout", 32'd0, 32'd1);
        tick();
        chk("held_idle_busy", busy4, 1'b0);
        chk("held_idle_done", done4, 1'b0);
        repeat (10) tick();
        chk("held_f0", flog[0][0], 16'h8400);
        chk("held_f1", flog[0][1], 16'h84FF);
        chk("held_f2", flog[0][2], 16'h845A);
        chk("held_frames", fcnt[0], 3);
        chk("held_done", done_cnt[0], 3);
        chk("held_gaps", gcnt[0], 2);
        chk("held_gap0", glog[0][0], 4);
        chk("held_gap1", glog[0][1], 4);
        chk("held_timing", viol[0], 0);

        // reset mid-frame after the 7th rise
        clear_mon();
        send4(1'b1, 7'h04, 8'hA5);
        n = 0;
        while (rises[0] < 7 && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) chk("abort_timeout", 32'd0, 32'd1);
        rst = 1'b1;
        tick();
        chk("abort_ncs", ncs4, 1'b1);
        chk("abort_sclk", sclk4, 1'b0);
        chk("abort_busy", busy4, 1'b0);
        chk("abort_done", done4, 1'b0);
        rst = 1'b0;
        dn = 0;
        repeat (200) begin
            tick();
            if (done4) dn++;
        end
        chk("abort_no_done", dn, 0);
        clear_mon();
        send4(1'b1, 7'h01, 8'h33);
        wait_done(0, 1, "post_timeout");
        chk("post_frame", flog[0][0], 16'h8133);
        chk("post_rises", frise[0][0], 16);
        chk("post_timing", viol[0], 0);
        chk("post_done", done_cnt[0], 1);

        // read frame, peripheral returns 0x3C on bits 8..15
        clear_mon();
        resp = 16'h003C;
        send4(1'b0, 7'h02, 8'h00);
        wait_done(0, 1, "rd_timeout");
        chk("rd_frame", flog[0][0], 16'h0200);
        chk("rd_at_done", rd_at_done[0], exp_rd);
        chk("rd_hold", rdata4, exp_rd);
        send4(1'b1, 7'h05, 8'h77);
        wait_done(0, 2, "rd_w_timeout");
        chk("rd_keep", rdata4, exp_rd);
        chk("rd_timing", viol[0], 0);

        // CLK_DIV=7 frame
        clear_mon();
        wr7 = 1'b1; addr7 = 7'h02; wdata7 = 8'h03; start7 = 1'b1;
        tick();
        start7 = 1'b0;
        wdata7 = 8'hFF;
        wait_done(1, 1, "d7_timeout");
        chk("d7_frame", flog[1][0], 16'h8203);
        chk("d7_rises", frise[1][0], 16);
        chk("d7_ncs_low", last_low[1], 238);
        chk("d7_timing", viol[1], 0);
        chk("d7_done", done_cnt[1], 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
